sap_controller_sequencer: RTL and testbench
===========================================

Name: sap_controller_sequencer

Overview:
- Control unit for the SAP datapath. It generates the control word that sequences fetch and execute on the shared 8-bit bus: load/enable strobes for the PC, MAR, RAM, IR, A, B and OUT registers, plus `su` and `eu` for the ALU.
- A one-hot ring counter drives six T-states per instruction. Decode uses the opcode nibble from the instruction register.
- The block is the initiator for the ALU's `su`/`eu` control interface and for every bus tri-state enable.

Parameters:
- OP_LDA, 4'b0000, load A from RAM[addr]
- OP_ADD, 4'b0001, A <= A + RAM[addr]
- OP_SUB, 4'b0010, A <= A - RAM[addr]
- OP_OUT, 4'b1110, OUT <= A
- OP_HLT, 4'b1111, stop sequencing

Ports:
- clk, input, 1, system clock; all state changes on the rising edge
- clr_n, input, 1, synchronous active-low reset
- opcode, input, 4, IR[7:4]; valid from T4 until the next T3
- cp, output, 1, PC increment
- ep, output, 1, PC drives bus
- lm, output, 1, MAR load from bus
- ce, output, 1, RAM drives bus
- li, output, 1, IR load from bus
- ei, output, 1, IR[3:0] drives bus
- la, output, 1, A load from bus
- ea, output, 1, A drives bus
- lb, output, 1, B load from bus
- su, output, 1, ALU mode: 0 = add, 1 = subtract
- eu, output, 1, ALU drives bus
- lo, output, 1, OUT register load from bus
- hlt, output, 1, halted flag
- t_state, output, 6, one-hot ring state; bit0 = T1 … bit5 = T6

Behaviour:
- **Reset.** With clr_n=0 at a rising edge: t_state <= 6'b000001 (T1) and hlt <= 0. Reset is synchronous only; clr_n has no effect between edges.
- **Outputs during reset.** While clr_n=0, all control outputs (cp..lo) are forced to 0 combinationally. No bus driver is enabled during clear. This applies even mid-instruction.
- **Ring counter.** Advances T1→T2→…→T6→T1 on each rising edge when clr_n=1 and hlt=0. If hlt=1 the ring holds its value.
- **Control decode.** Control outputs are combinational from t_state and opcode. All outputs not listed for a state are 0.
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
  - LDA: T4 ei, lm; T5 ce, la; T6 none.
  - ADD: T4 ei, lm; T5 ce, lb; T6 eu, la, su=0.
  - SUB: T4 ei, lm; T5 ce, lb, su=1; T6 eu, la, su=1. su is asserted in T5 as well so the ALU result has settled before eu.
  - OUT: T4 ea, lo; T5 and T6 none.
  - HLT: T4 none. At the T4 rising edge with opcode==OP_HLT, hlt <= 1 and the ring stays at T4.
  - Undefined opcodes: T4–T6 issue no controls (NOP). The ring continues.
- **Opcode timing.** opcode is ignored in T1–T3. IR is loaded at the end of T3, so opcode is stable for T4–T6.
- **Halted state.**
  - hlt=1 forces all control outputs to 0 and freezes t_state.
  - Only clr_n=0 at an edge clears it.
  - clr_n=0 and halt detection at the same edge: reset wins, giving T1 with hlt=0.
- **Bus invariant.** At most one of ep, ce, ei, ea, eu is 1 in any cycle. The verification engineer asserts this every cycle.
- **Latency.**
  - LDA, ADD, SUB and OUT each take exactly 6 clocks.
  - The fetch of the next instruction begins at the edge after T6.
  - HLT takes 4 clocks to assert hlt. hlt is visible in the cycle after the T4 edge.

Test Plan:
- Reset: hold clr_n=0 for 2 clocks from an arbitrary state → t_state=000001, hlt=0, all controls 0 while clr_n=0. After release: T1 shows ep=1, lm=1.
- LDA fetch/execute: opcode=0000 → per-cycle controls T1 {ep,lm}, T2 {cp}, T3 {ce,li}, T4 {ei,lm}, T5 {ce,la}, T6 {}. t_state wraps to 000001 after 6 edges.
- ADD then SUB: opcode=0001 → T6 shows eu=1, la=1, su=0. Next instruction opcode=0010 → T5 shows {ce,lb,su}, T6 shows {eu,la,su=1}. Bus-driver one-hot assertion holds throughout.
- OUT and undefined opcode: opcode=1110 → T4 {ea,lo}. opcode=0101 → T4–T6 all zero, and the ring continues to T1.
- HLT: opcode=1111 → hlt=1 after the T4 edge. t_state stays 001000 and controls stay 0 for 20 clocks. clr_n=0 for one edge → T1, hlt=0.
- Reset mid-instruction: ADD running; assert clr_n=0 in T5 → controls immediately 0. Next edge gives t_state=000001, and no la/eu pulse occurs.

Source files
------------

// File: rtl/sap_controller_sequencer.sv
// SAP control unit: six-state one-hot ring counter plus combinational decode of
// the control word (bus enables, register loads, ALU mode) from T-state and opcode.
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state;

  assign t_state = state;

  // A halt seen in T4 freezes the ring at T4; only a clear releases it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!clr_n) begin
      state <= T1;
      hlt   <= 1'b0;
    end else if (!hlt) begin
      if (state == T4 && opcode == OP_HLT) begin
        hlt <= 1'b1;
      end else begin
        case (state)
          T1:      state <= T2;
          T2:      state <= T3;
          T3:      state <= T4;
          T4:      state <= T5;
          T5:      state <= T6;
          default: state <= T1;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    lb = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lo = 1'b0;
    // Clear and halt both silence the whole control word, even mid-instruction.
    if (clr_n && !hlt) begin
      case (state)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            // su leads eu by a cycle so the subtract result is settled on the bus.
            OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              eu = 1'b1;
              la = 1'b1;
            end
            OP_SUB: begin
              eu = 1'b1;
              la = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench for sap_controller_sequencer: directed scenarios plus
// randomized instruction streams against a step-counter reference model.
module tb_sap_controller_sequencer;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] opcode;
  logic       cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo, hlt;
  logic [5:0] t_state;

  int total = 0;
  int bad   = 0;

  // Reference model: instruction step 0..5 (T1..T6) and halted flag.
  int   m_step = 0;
  logic m_hlt  = 1'b0;

  always #5 clk = ~clk;

  sap_controller_sequencer dut (
    .clk(clk), .clr_n(clr_n), .opcode(opcode),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
    .lb(lb), .su(su), .eu(eu), .lo(lo), .hlt(hlt), .t_state(t_state)
  );

  function automatic ctrl_t exp_ctrl(int step, logic [3:0] op, logic clr, logic h);
    ctrl_t c = '0;
    if (!clr || h) return c;
    case (step)
      0: begin c.ep = 1; c.lm = 1; end
      1: c.cp = 1;
      2: begin c.ce = 1; c.li = 1; end
      3: if (op == OP_LDA || op == OP_ADD || op == OP_SUB) begin c.ei = 1; c.lm = 1; end
         else if (op == OP_OUT) begin c.ea = 1; c.lo = 1; end
      4: if (op == OP_LDA) begin c.ce = 1; c.la = 1; end
         else if (op == OP_ADD) begin c.ce = 1; c.lb = 1; end
         else if (op == OP_SUB) begin c.ce = 1; c.lb = 1; c.su = 1; end
      5: if (op == OP_ADD) begin c.eu = 1; c.la = 1; end
         else if (op == OP_SUB) begin c.eu = 1; c.la = 1; c.su = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // One clock: drive at posedge+1, compare mid-cycle, then advance the model.
  task automatic cycle(input logic clr, input logic [3:0] op, input string tag);
    ctrl_t       want, got;
    logic [11:0] wv, gv;
    logic [5:0]  want_t;
    clr_n  = clr;
    opcode = op;
    #4;
    want   = exp_ctrl(m_step, op, clr, m_hlt);
    got    = {cp, ep, lm, ce, li, ei, la, ea, lb, su, eu, lo};
    wv     = want;
    gv     = got;
    want_t = 6'b000001 << m_step;
    total++;
    if (t_state !== want_t) begin
      bad++;
      $display("FAIL %s t_state: got %b want %b", tag, t_state, want_t);
    end
    total++;
    if (hlt !== m_hlt) begin
      bad++;
      $display("FAIL %s hlt: got %b want %b", tag, hlt, m_hlt);
    end
    total++;
    if (gv !== wv) begin
      bad++;
      $display("FAIL %s ctrl{cp,ep,lm,ce,li,ei,la,ea,lb,su,eu,lo}: got %b want %b", tag, gv, wv);
    end
    total++;
    if ($countones({ep, ce, ei, ea, eu}) > 1) begin
      bad++;
      $display("FAIL %s bus_onehot: got %b want at most one set", tag, {ep, ce, ei, ea, eu});
    end
    @(posedge clk);
    if (!clr) begin
      m_step = 0;
      m_hlt  = 1'b0;
    end else if (!m_hlt) begin
      if (m_step == 3 && op == OP_HLT) m_hlt = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
    #1;
  endtask

  // Opcode is garbage during fetch (T1..T3) and holds op for T4..T6.
  task automatic run_instr(input logic [3:0] op, input string tag);
    for (int k = 0; k < 6; k++)
      cycle(1'b1, (k < 3) ? 4'($urandom) : op, tag);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'($urandom), "reset_pre");
    cycle(1'b0, 4'($urandom), "reset_hold0");
    cycle(1'b0, 4'($urandom), "reset_hold1");
    cycle(1'b1, 4'($urandom), "reset_t1");
    cycle(1'b0, 4'($urandom), "reset_realign");
  endtask

  task automatic test_lda();
    run_instr(OP_LDA, "lda");
    cycle(1'b1, 4'($urandom), "lda_wrap");
    cycle(1'b0, 4'($urandom), "lda_realign");
  endtask

  task automatic test_add_sub();
    run_instr(OP_ADD, "add");
    run_instr(OP_SUB, "sub");
    run_instr(OP_SUB, "sub2");
    run_instr(OP_ADD, "add2");
  endtask

  task automatic test_out_undef();
    run_instr(OP_OUT, "out");
    run_instr(4'b0101, "undef");
    run_instr(OP_LDA, "after_undef");
  endtask

  task automatic test_hlt();
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'($urandom), "hlt_fetch");
    cycle(1'b1, OP_HLT, "hlt_t4");
    for (int k = 0; k < 20; k++) cycle(1'b1, (k % 2) ? OP_HLT : 4'($urandom), "hlt_hold");
    cycle(1'b0, OP_HLT, "hlt_clear");
    run_instr(OP_LDA, "hlt_after");
    // Clear and halt detection on the same edge: clear wins.
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'($urandom), "hlt_race_fetch");
    cycle(1'b0, OP_HLT, "hlt_race");
    run_instr(OP_ADD, "hlt_race_after");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'($urandom), "mid_fetch");
    cycle(1'b1, OP_ADD, "mid_t4");
    cycle(1'b0, OP_ADD, "mid_t5_clr");
    run_instr(OP_SUB, "mid_after");
  endtask

  task automatic test_random();
    logic [3:0] op = OP_LDA;
    for (int n = 0; n < 400; n++) begin
      logic clr = ($urandom_range(0, 24) != 0);
      if (m_step == 3 && !m_hlt) begin
        case ($urandom_range(0, 5))
          0: op = OP_LDA;
          1: op = OP_ADD;
          2: op = OP_SUB;
          3: op = OP_OUT;
          4: op = ($urandom_range(0, 3) == 0) ? OP_HLT : OP_ADD;
          default: op = 4'($urandom);
        endcase
      end
      cycle(clr, (m_step < 3 && !m_hlt) ? 4'($urandom) : op, "random");
    end
  endtask

  initial begin
    clr_n  = 1'b0;
    opcode = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    m_step = 0;
    m_hlt  = 1'b0;
    test_reset();
    test_lda();
    test_add_sub();
    test_out_undef();
    test_hlt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
